// File: rtl/mmio_interconnect.sv
// -----------------------------------------------------------------------------
// mmio_interconnect
//
// Memory-mapped I/O interconnect between the CPU data port and NUM_SLAVES
// peripherals. A request accepted in IDLE is decoded on the region field
// cpu_addr[SEL_LSB +: SEL_W] into a one-hot slave select. The access is then
// held in ACCESS until the selected slave raises s_ready or the wait budget
// runs out. RESP returns a one-cycle cpu_ready pulse with registered read data
// and an error flag. Every output is driven directly from a flop.
//
// Ports:
//   clock, reset                 rising-edge clock, async active-low reset
//   cpu_req/we/addr/wdata        CPU request (req held until cpu_ready)
//   cpu_rdata/ready/err          registered response
//   s_sel/we/addr/wdata          slave request (one-hot select, latched values)
//   s_rdata, s_ready             per-slave read data slices and completion
//   err_count                    saturating count of errored accesses
// -----------------------------------------------------------------------------
module mmio_interconnect #(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int SEL_LSB    = 8,
  parameter int SEL_W      = 4,
  parameter logic [NUM_SLAVES*SEL_W-1:0] SLAVE_REGIONS = {4'd10, 4'd9, 4'd8, 4'd0},
  parameter int TIMEOUT    = 15
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         cpu_req,
  input  logic                         cpu_we,
  input  logic [ADDR_W-1:0]            cpu_addr,
  input  logic [DATA_W-1:0]            cpu_wdata,
  output logic [DATA_W-1:0]            cpu_rdata,
  output logic                         cpu_ready,
  output logic                         cpu_err,
  output logic [NUM_SLAVES-1:0]        s_sel,
  output logic                         s_we,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]        s_ready,
  output logic [7:0]                   err_count
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  // The wait counter only has to reach TIMEOUT-1; with TIMEOUT=0 it may wrap.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    we_q, we_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [NUM_SLAVES-1:0]   sel_q, sel_d;
  logic                    s_we_q, s_we_d;
  logic [CNT_W-1:0]        wait_q, wait_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic                    ready_q, ready_d;
  logic                    err_q, err_d;
  logic [7:0]              err_count_q, err_count_d;

  logic                    dec_hit;
  logic [IDX_W-1:0]        dec_idx;

  // Region decode. Scanning from the top down lets the lowest matching
  // index overwrite the others, so it wins when regions overlap.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (cpu_addr[SEL_LSB +: SEL_W] == SLAVE_REGIONS[i*SEL_W +: SEL_W]) begin
        dec_hit = 1'b1;
        dec_idx = IDX_W'(i);
      end
    end
  end

  // NOTE: every variable assigned here gets a default first, so no path
  // through the case statement leaves one unassigned and infers a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sel_d       = '0;
    s_we_d      = 1'b0;
    wait_d      = wait_q;
    rdata_d     = rdata_q;
    ready_d     = 1'b0;
    err_d       = 1'b0;
    err_count_d = err_count_q;

    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          if (dec_hit) begin
            idx_d          = dec_idx;
            we_d           = cpu_we;
            addr_d         = cpu_addr;
            wdata_d        = cpu_wdata;
            sel_d[dec_idx] = 1'b1;
            s_we_d         = cpu_we;
            wait_d         = '0;
            state_d        = ACCESS;
          end else begin
            // Unmapped region: answer straight away with an error.
            ready_d = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = RESP;
          end
        end
      end

      ACCESS: begin
        if (s_ready[idx_q]) begin
          ready_d = 1'b1;
          rdata_d = we_q ? '0 : s_rdata[idx_q*DATA_W +: DATA_W];
          state_d = RESP;
        end else if (TIMEOUT != 0 && wait_q == WAIT_LAST) begin
          ready_d = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else begin
          sel_d  = sel_q;
          s_we_d = we_q;
          wait_d = wait_q + CNT_W'(1);
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (err_d && err_count_q != 8'hFF) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      s_we_q      <= 1'b0;
      wait_q      <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      s_we_q      <= s_we_d;
      wait_q      <= wait_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign cpu_rdata = rdata_q;
  assign cpu_ready = ready_q;
  assign cpu_err   = err_q;
  assign s_sel     = sel_q;
  assign s_we      = s_we_q;
  assign s_addr    = addr_q;
  assign s_wdata   = wdata_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_mmio_interconnect.sv
// -----------------------------------------------------------------------------
// tb_mmio_interconnect
//
// Scoreboard bench for mmio_interconnect with default parameters. The driver
// computes each access's expected outcome from the address map, the slave's
// wait count and the timeout budget, then queues it. A monitor pops and
// compares whenever cpu_ready is seen. A slave model answers the selected
// slave after a programmed number of wait cycles and checks what it is
// presented with.
// -----------------------------------------------------------------------------
module tb_mmio_interconnect;

  localparam int NS      = 4;
  localparam int TIMEOUT = 15;
  localparam int REGIONS [NS] = '{0, 8, 9, 10};

  logic          clock;
  logic          reset;
  logic          cpu_req;
  logic          cpu_we;
  logic [31:0]   cpu_addr;
  logic [31:0]   cpu_wdata;
  logic [31:0]   cpu_rdata;
  logic          cpu_ready;
  logic          cpu_err;
  logic [NS-1:0] s_sel;
  logic          s_we;
  logic [31:0]   s_addr;
  logic [31:0]   s_wdata;
  logic [NS*32-1:0] s_rdata;
  logic [NS-1:0] s_ready;
  logic [7:0]    err_count;

  mmio_interconnect dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .cpu_err   (cpu_err),
    .s_sel     (s_sel),
    .s_we      (s_we),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_rdata   (s_rdata),
    .s_ready   (s_ready),
    .err_count (err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  errcnt;
    int          lat;
    int          issue;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int model_errs = 0;

  // Current access as the slave model should see it.
  logic [NS-1:0] cur_sel;
  logic          cur_we;
  logic [31:0]   cur_addr;
  logic [31:0]   cur_wdata;
  int            cur_acc;
  int            cfg_waits;
  int            acc_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave index owning an address, -1 when the region is unmapped.
  function automatic int model_decode(input logic [31:0] addr);
    for (int i = 0; i < NS; i++) begin
      if (int'(addr[11:8]) == REGIONS[i]) return i;
    end
    return -1;
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clock) begin
    exp_t e;
    if (reset && cpu_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 64'(cpu_ready), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("rdata",     64'(cpu_rdata), 64'(e.rdata));
        check("err",       64'(cpu_err),   64'(e.err));
        check("err_count", 64'(err_count), 64'(e.errcnt));
        check("latency",   64'(cyc - e.issue), 64'(e.lat));
      end
    end
  end

  // Slave model: the selected slave raises ready after cfg_waits ACCESS
  // cycles; unselected ready bits carry noise that must be ignored.
  always @(negedge clock) begin
    logic [NS-1:0] noise;
    noise = NS'($urandom);
    if (!reset) begin
      acc_cnt = 0;
      s_ready = '0;
    end else if (s_sel != '0) begin
      if (acc_cnt == 0) begin
        check("s_sel",   64'(s_sel),   64'(cur_sel));
        check("s_we",    64'(s_we),    64'(cur_we));
        check("s_addr",  64'(s_addr),  64'(cur_addr));
        check("s_wdata", 64'(s_wdata), 64'(cur_wdata));
      end
      s_ready = ((acc_cnt == cfg_waits) ? s_sel : '0) | (noise & ~s_sel);
      acc_cnt++;
    end else begin
      if (acc_cnt != 0) begin
        check("access_cycles", 64'(acc_cnt), 64'(cur_acc));
        check("s_we_idle",     64'(s_we),    64'(0));
        acc_cnt = 0;
      end else if (cur_acc == 0 && cpu_ready) begin
        // Decode error: no select activity for the whole access.
        check("no_sel_on_decode_err", 64'(s_sel), 64'(0));
      end
      s_ready = noise;
    end
  end

  function automatic logic [7:0] bump_errs();
    if (model_errs < 255) model_errs++;
    return 8'(model_errs);
  endfunction

  // One complete access; rd is the selected slave's read data.
  task automatic do_access(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                           input int waits, input logic [31:0] rd, input bit scramble);
    exp_t e;
    int idx;
    int n;
    logic [31:0] junk;
    idx = model_decode(addr);
    for (int i = 0; i < NS; i++) s_rdata[i*32 +: 32] = $urandom;
    if (idx >= 0) s_rdata[idx*32 +: 32] = rd;
    cfg_waits = waits;
    cur_sel   = (idx >= 0) ? NS'(1 << idx) : '0;
    cur_we    = we;
    cur_addr  = addr;
    cur_wdata = wdata;
    if (idx < 0) begin
      e.err = 1'b1; e.rdata = '0; e.lat = 1; cur_acc = 0;
    end else if (waits < TIMEOUT) begin
      e.err = 1'b0; e.rdata = we ? 32'h0 : rd; e.lat = waits + 2; cur_acc = waits + 1;
    end else begin
      e.err = 1'b1; e.rdata = '0; e.lat = TIMEOUT + 1; cur_acc = TIMEOUT;
    end
    e.errcnt = e.err ? bump_errs() : 8'(model_errs);
    e.issue  = cyc;
    exp_q.push_back(e);
    cpu_addr  = addr;
    cpu_we    = we;
    cpu_wdata = wdata;
    cpu_req   = 1'b1;
    @(negedge clock);
    if (scramble) begin
      junk = $urandom; cpu_addr = junk;
      junk = $urandom; cpu_wdata = junk;
      cpu_we = ~we;
      if (!cpu_ready && $urandom_range(1) == 1) cpu_req = 1'b0;
    end
    n = 0;
    while (!cpu_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!cpu_ready) begin
      check("ready_within_bound", 64'(cpu_ready), 64'(1));
      void'(exp_q.pop_front());
    end
    cpu_req = 1'b0;
    @(negedge clock);  // back in IDLE
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int          regs [6];
    int          count;
    int          n;
    int          base;
    exp_t        e;

    reset     = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    s_rdata   = '0;
    s_ready   = '0;
    cur_acc   = 0;
    cfg_waits = 0;
    cur_sel   = '0;
    cur_we    = 1'b0;
    cur_addr  = '0;
    cur_wdata = '0;
    #1;
    check("rst_cpu_ready", 64'(cpu_ready), 64'(0));
    check("rst_cpu_rdata", 64'(cpu_rdata), 64'(0));
    check("rst_s_sel",     64'(s_sel),     64'(0));
    check("rst_err_count", 64'(err_count), 64'(0));
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Directed cases.
    do_access(32'h0000_0804, 1'b0, 32'h0,     0,    32'hDEAD_BEEF, 1'b0);
    do_access(32'h0000_0908, 1'b1, 32'h1F,    3,    32'h1234_5678, 1'b0);
    do_access(32'h0000_0500, 1'b0, 32'h0,     0,    32'h0,         1'b0);
    check("err_count_after_decode_err", 64'(err_count), 64'(1));
    do_access(32'h0000_0A40, 1'b0, 32'h0,     1000, 32'h5555_AAAA, 1'b0);
    do_access(32'h0000_0A44, 1'b0, 32'h0,     14,   32'hCAFE_F00D, 1'b0);
    do_access(32'h0000_0A48, 1'b1, 32'h77,    15,   32'h0,         1'b0);
    do_access(32'h0000_0010, 1'b0, 32'h0,     2,    32'h0BAD_CAFE, 1'b1);

    // Reset in the middle of an access: everything clears, no response.
    cur_sel = 4'b1000; cur_we = 1'b1; cur_addr = 32'h0000_0A00; cur_wdata = 32'hFEED_0001;
    cur_acc = 0; cfg_waits = 1000;
    cpu_addr = 32'h0000_0A00; cpu_we = 1'b1; cpu_wdata = 32'hFEED_0001; cpu_req = 1'b1;
    repeat (4) @(negedge clock);
    cpu_req = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("arst_cpu_rdata", 64'(cpu_rdata), 64'(0));
    check("arst_cpu_ready", 64'(cpu_ready), 64'(0));
    check("arst_cpu_err",   64'(cpu_err),   64'(0));
    check("arst_s_sel",     64'(s_sel),     64'(0));
    check("arst_s_we",      64'(s_we),      64'(0));
    check("arst_s_addr",    64'(s_addr),    64'(0));
    check("arst_s_wdata",   64'(s_wdata),   64'(0));
    check("arst_err_count", 64'(err_count), 64'(0));
    model_errs = 0;
    repeat (3) begin
      @(negedge clock);
      check("arst_no_ready", 64'(cpu_ready), 64'(0));
    end
    reset = 1'b1;
    @(negedge clock);
    do_access(32'h0000_0800, 1'b0, 32'h0, 1, 32'h0F0F_1234, 1'b0);

    // Randomized traffic over mapped, unmapped and arbitrary regions.
    regs = '{0, 8, 9, 10, 5, 0};
    for (int k = 0; k < 150; k++) begin
      regs[5] = $urandom_range(15);
      a = $urandom;
      a[11:8] = 4'(regs[$urandom_range(5)]);
      d = $urandom;
      n = ($urandom_range(9) == 0) ? $urandom_range(13, 20) : $urandom_range(4);
      do_access(a, 1'(($urandom_range(1))), d, n, $urandom, 1'($urandom_range(1)));
    end

    // Back-to-back decode errors with cpu_req held high.
    cur_sel = '0; cur_acc = 0;
    cpu_addr = 32'h0000_0500; cpu_we = 1'b0; cpu_req = 1'b1;
    base = cyc;
    for (int k = 0; k < 260; k++) begin
      e.err = 1'b1; e.rdata = '0; e.lat = 1; e.issue = base + 2 * k;
      e.errcnt = bump_errs();
      exp_q.push_back(e);
    end
    count = 0;
    n = 0;
    while (count < 260 && n < 2000) begin
      @(negedge clock);
      n++;
      if (cpu_ready) count++;
    end
    cpu_req = 1'b0;
    check("b2b_responses", 64'(count), 64'(260));
    repeat (3) @(negedge clock);
    check("err_count_saturated", 64'(err_count), 64'(255));
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
